// File: rtl/galois_pkg.sv
// Shared types and the Galois LFSR next-state function used by the PRBS
// generator/checker pair.
package galois_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Widest LFSR supported by galois_step; callers zero-extend and truncate.
  localparam int GALOIS_W = 64;

  function automatic logic [GALOIS_W-1:0] galois_step(
    input logic [GALOIS_W-1:0] lfsr,
    input logic [GALOIS_W-1:0] taps,
    input int unsigned         n
  );
    logic fb;
    fb = lfsr[6'(n - 1)];
    return (lfsr << 1) ^ (fb ? taps : '0);
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// N-bit Galois LFSR register: reset to all ones, load from seed, or step.
module prbs_lfsr_core
  import galois_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         step,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] taps,
  output logic [N-1:0] q,
  output logic         msb
);

  logic [GALOIS_W-1:0] nxt_w;

  assign nxt_w = galois_step(GALOIS_W'(q), GALOIS_W'(taps), N);
  assign msb   = q[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '1;
    end else if (ld) begin
      q <= seed;
    end else if (step) begin
      q <= nxt_w[N-1:0];
    end
  end

endmodule

// File: rtl/galois_prbs_checker.sv
// Receive-side PRBS checker: aligns a local Galois LFSR to the incoming bit
// stream by slipping during HUNT, then counts bit errors while LOCKED.
module galois_prbs_checker
  import galois_pkg::*;
#(
  parameter int N        = 32,
  parameter int LOCK_CNT = N,
  parameter int LOSS_CNT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          ld,
  input  logic [N-1:0]  taps,
  input  logic [N-1:0]  seed_i,
  input  logic          bit_vld,
  input  logic          bit_i,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] slip_cnt,
  output logic [1:0]    state_o
);

  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

  state_t        state;
  logic [RW-1:0] run;
  logic [MW-1:0] miss;
  logic [N-1:0]  lfsr_q;
  logic          exp_bit;
  logic          check;
  logic          match;
  logic          step;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ld drops any bit in the same cycle; IDLE never checks.
  assign check = en & bit_vld & ~ld & (state != ST_IDLE);
  assign match = (bit_i == exp_bit);
  // Mismatch in HUNT holds the LFSR, delaying the local sequence by one bit.
  assign step  = check & (match | (state == ST_LOCKED));

  prbs_lfsr_core #(.N(N)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .step  (step),
    .seed  (seed_i),
    .taps  (taps),
    .q     (lfsr_q),
    .msb   (exp_bit)
  );

  assign state_o = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run       <= '0;
      miss      <= '0;
      err_cnt   <= '0;
      slip_cnt  <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (ld) begin
        state    <= ST_HUNT;
        locked   <= 1'b0;
        run      <= '0;
        miss     <= '0;
        err_cnt  <= '0;
        slip_cnt <= '0;
      end else if (en) begin
        case (state)
          ST_IDLE: begin
            state <= ST_HUNT;
          end
          ST_HUNT: begin
            if (bit_vld) begin
              if (match) begin
                if (run == RUN_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  run    <= '0;
                end else begin
                  run <= run + 1'b1;
                end
              end else begin
                run      <= '0;
                slip_cnt <= sat_inc(slip_cnt);
              end
            end
          end
          ST_LOCKED: begin
            if (bit_vld) begin
              if (match) begin
                miss <= '0;
              end else begin
                err_cnt   <= sat_inc(err_cnt);
                err_pulse <= 1'b1;
                if (miss == MISS_LAST) begin
                  state  <= ST_HUNT;
                  locked <= 1'b0;
                  run    <= '0;
                  miss   <= '0;
                end else begin
                  miss <= miss + 1'b1;
                end
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_galois_prbs_checker.sv
// Bench for galois_prbs_checker: two instances (CW=16 and CW=2) share the
// stimulus; a position-based model of the PRBS sequence predicts outputs.
module tb_galois_prbs_checker;

  localparam int N        = 8;
  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 4;
  localparam logic [7:0] TAPS = 8'hB8;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ld;
  logic [7:0]  taps;
  logic [7:0]  seed_i;
  logic        bit_vld;
  logic        bit_i;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_cnt_a, slip_cnt_a;
  logic [1:0]  state_a;
  logic        locked_b, err_pulse_b;
  logic [1:0]  err_cnt_b, slip_cnt_b;
  logic [1:0]  state_b;

  galois_prbs_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .taps(taps), .seed_i(seed_i),
    .bit_vld(bit_vld), .bit_i(bit_i), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_cnt(err_cnt_a), .slip_cnt(slip_cnt_a), .state_o(state_a)
  );

  galois_prbs_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .taps(taps), .seed_i(seed_i),
    .bit_vld(bit_vld), .bit_i(bit_i), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_cnt(err_cnt_b), .slip_cnt(slip_cnt_b), .state_o(state_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // The PRBS sequence is tabulated once; checker and generator are positions in it.
  logic [7:0] seq[0:255];
  int period;
  int gen_ptr;
  int m_mode;      // 0 idle, 1 hunt, 2 locked
  int m_ptr, m_run, m_miss, m_errs, m_slips;
  int checks = 0;
  int errors = 0;

  // {state(2), locked, pulse, err16, slip16, err2, slip2}
  logic [39:0] exp_q[$];

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic build_seq();
    logic [7:0] s;
    s = 8'hFF;
    period = 256;
    for (int i = 0; i < 256; i++) begin
      seq[i] = s;
      s = {s[6:0], 1'b0} ^ (s[7] ? TAPS : 8'h00);
      if (s == 8'hFF) begin
        period = i + 1;
        break;
      end
    end
  endtask

  task automatic model(input logic r, input logic e, input logic l, input int idx,
                       input logic v, input logic b);
    logic pulse;
    logic expb;
    logic [39:0] x;
    pulse = 1'b0;
    if (!r) begin
      m_mode = 0; m_ptr = 0; m_run = 0; m_miss = 0; m_errs = 0; m_slips = 0;
    end else if (l) begin
      m_mode = 1; m_ptr = idx; m_run = 0; m_miss = 0; m_errs = 0; m_slips = 0;
    end else if (e) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (v) begin
        expb = seq[m_ptr][7];
        if (m_mode == 1) begin
          if (b == expb) begin
            m_ptr = (m_ptr + 1) % period;
            m_run++;
            if (m_run == LOCK_CNT) begin
              m_mode = 2;
              m_run  = 0;
            end
          end else begin
            m_run = 0;
            m_slips++;
          end
        end else begin
          m_ptr = (m_ptr + 1) % period;
          if (b == expb) begin
            m_miss = 0;
          end else begin
            m_errs++;
            pulse = 1'b1;
            m_miss++;
            if (m_miss == LOSS_CNT) begin
              m_mode = 1; m_run = 0; m_miss = 0;
            end
          end
        end
      end
    end
    x = {2'(m_mode), (m_mode == 2), pulse, 16'(sat(m_errs, 16)), 16'(sat(m_slips, 16)),
         2'(sat(m_errs, 2)), 2'(sat(m_slips, 2))};
    exp_q.push_back(x);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic l, input int idx,
                       input logic v, input logic flip);
    logic b;
    logic consumed;
    @(negedge clk);
    b = seq[gen_ptr][7] ^ flip;
    consumed = r & ~l & e & v & (m_mode != 0);
    rst_n   = r;
    en      = e;
    ld      = l;
    seed_i  = seq[idx];
    bit_vld = v;
    bit_i   = b;
    model(r, e, l, idx, v, b);
    if (consumed) gen_ptr = (gen_ptr + 1) % period;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic load(input int idx, input int gptr);
    drive(1'b1, 1'b1, 1'b1, idx, 1'b0, 1'b0);
    gen_ptr = gptr;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    logic [39:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("state_o",     state_a,     x[39:38]);
        chk("locked",      locked_a,    x[37]);
        chk("err_pulse",   err_pulse_a, x[36]);
        chk("err_cnt",     err_cnt_a,   x[35:20]);
        chk("slip_cnt",    slip_cnt_a,  x[19:4]);
        chk("sat_state_o", state_b,     x[39:38]);
        chk("sat_locked",  locked_b,    x[37]);
        chk("sat_err_cnt", err_cnt_b,   x[3:2]);
        chk("sat_slip_cnt", slip_cnt_b, x[1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    taps = TAPS; rst_n = 1'b0; en = 1'b0; ld = 1'b0;
    seed_i = 8'h00; bit_vld = 1'b0; bit_i = 1'b0;
    build_seq();
    gen_ptr = 0;
    m_mode = 0; m_ptr = 0; m_run = 0; m_miss = 0; m_errs = 0; m_slips = 0;

    // Reset, then leave IDLE with en
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);

    // Aligned: both seeded 8'hFF
    load(0, 0);
    stream(20);

    // Offset: checker three steps ahead of the generator
    load(3, 0);
    stream(30);

    // Single error while locked
    drive(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    stream(6);

    // Four consecutive errors force loss of lock, then relock
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    stream(12);

    // en low: bits ignored, nothing advances
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'(i & 1));
    stream(4);

    // ld with bit_vld in the same cycle drops the bit
    drive(1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b1);
    gen_ptr = 5;
    stream(10);

    // Reset mid-stream for two cycles
    drive(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 7, 1'b1, 1'b1);
    stream(3);

    // Randomized traffic
    load(0, 0);
    for (int i = 0; i < 600; i++) begin
      logic r, e, l, v, f;
      int idx;
      r   = ($urandom_range(0, 199) != 0);
      l   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 9) != 0);
      v   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 19) == 0);
      idx = $urandom_range(0, period - 1);
      drive(r, e, l, idx, v, f);
      if (r && l) gen_ptr = $urandom_range(0, period - 1);
    end

    drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
